// File: rtl/ntt_sched_pkg.sv
// Shared constants, stage-offset helper and FSM state type for the NTT pipeline sequencer.
package ntt_sched_pkg;

    localparam int NTT_STAGE_CNT     = 7;
    localparam int NTT_MUL_STAGE_CNT = 4;
    localparam int NTT_POLY_CYCLES   = 128;

    // Cycle at which a beat enters stage i: each earlier stage costs its 2^s fifo plus the multiplier.
    function automatic int stage_off(input int i, input int mul_cnt);
        int d;
        d = 0;
        for (int s = 0; s < i; s++) d += (1 << s) + mul_cnt;
        return d;
    endfunction

    localparam int NTT_TOTAL = stage_off(NTT_STAGE_CNT, NTT_MUL_STAGE_CNT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/ntt_valid_line.sv
// Enable-gated 1-bit shift register; q[k] holds the valid bit accepted k enabled cycles ago.
module ntt_valid_line
    import ntt_sched_pkg::*;
#(
    parameter int LEN = NTT_TOTAL
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           din,
    output logic [LEN:1]   q
);

    // NOTE: clocked state is assigned with <= so every stage samples its neighbour's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= {q[LEN-1:1], din};
    end

endmodule

// File: rtl/ntt_pipe_sched.sv
// Sequencer for the pipelined NTT/INTT datapath: fifo advance, swap select, output valid, completion.
// Define NTT_SCHED_HOLD_EN to add the hold input that freezes the whole pipeline.
module ntt_pipe_sched
    import ntt_sched_pkg::*;
#(
    parameter int STAGE_CNT     = NTT_STAGE_CNT,
    parameter int MUL_STAGE_CNT = NTT_MUL_STAGE_CNT,
    parameter int POLY_CYCLES   = NTT_POLY_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
`ifdef NTT_SCHED_HOLD_EN
    input  logic hold,
`endif
    output logic in_ready,
    output logic fifo_en [STAGE_CNT],
    output logic swap    [STAGE_CNT],
    output logic out_valid,
    output logic poly_done,
    output logic busy,
    output logic err
);

    localparam int               TOTAL_L  = stage_off(STAGE_CNT, MUL_STAGE_CNT);
    localparam int               CNT_W    = $clog2(POLY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLY_CYCLES - 1);

    logic               en;
    logic               in_fire;
    logic [TOTAL_L:1]   vl_q;
    logic [TOTAL_L:0]   vl;
    logic [CNT_W-1:0]   oc_q;
    logic [CNT_W-1:0]   lc_q, lc_d;
    logic               err_q, err_d;
    logic               pipe_empty;
    sched_state_t       state_q, state_d;

`ifdef NTT_SCHED_HOLD_EN
    assign en = ~hold;
`else
    assign en = 1'b1;
`endif

    assign in_ready = en;
    assign in_fire  = in_valid & en;

    ntt_valid_line #(
        .LEN (TOTAL_L)
    ) u_valid_line (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (in_fire),
        .q     (vl_q)
    );

    assign vl = {vl_q, in_fire};

    for (genvar i = 0; i < STAGE_CNT; i++) begin : g_stage
        localparam int LO = stage_off(i, MUL_STAGE_CNT);
        localparam int HI = stage_off(i + 1, MUL_STAGE_CNT) - 1;

        logic [CNT_W-1:0] bc_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)             bc_q <= '0;
            else if (en && vl[LO])  bc_q <= bc_q + 1'b1;
        end

        // Gated by rst_n too: stage 0's window sees the combinational in_fire.
        assign fifo_en[i] = rst_n & en & (|vl[HI:LO]);

        if (i < CNT_W) begin : g_swap
            assign swap[i] = bc_q[i];
        end else begin : g_noswap
            assign swap[i] = 1'b0;
        end
    end

    assign out_valid  = vl[TOTAL_L];
    assign poly_done  = en & out_valid & (oc_q == CNT_LAST);
    assign pipe_empty = ~|vl[TOTAL_L-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 oc_q <= '0;
        else if (en && out_valid)   oc_q <= oc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal driven here gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = LOAD;
                    lc_d    = CNT_W'(1);
                end
            end
            LOAD: begin
                if (in_fire) begin
                    if (lc_q == CNT_LAST) begin
                        state_d = DRAIN;
                        lc_d    = '0;
                    end else begin
                        lc_d    = lc_q + 1'b1;
                    end
                end else if (en) begin
                    err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (in_fire) begin
                    state_d = LOAD;
                    lc_d    = CNT_W'(1);
                end else if (poly_done && pipe_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule
